demux_8: RTL and testbench
==========================

DEMUX_8 -- requirements
Module: demux_8

Interface
REQ-001 Parameter: width, default 32, data width of input and of each output channel.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: addr  input  3  destination channel select for the current write.
REQ-005 Port: in  input  width  write data.
REQ-006 Port: in_valid  input  1  write request this cycle.
REQ-007 Port: enable  input  1  active-low block enable; 1 = disabled/flush, 0 = operate.
REQ-008 Port: take  input  8  per-channel consume strobe from downstream; bit i acknowledges channel i.
REQ-009 Port: out0..out7  output  width each  registered channel data.
REQ-010 Port: valid  output  8  registered per-channel occupied flag.
REQ-011 Port: overflow  output  8  sticky per-channel overwrite-of-unconsumed-data flag.
REQ-012 Port: occupancy  output  4  registered count of set bits in valid, range 0..8.

Function
REQ-013 Write: when enable=0 and in_valid=1, out[addr] SHALL load in and valid[addr] SHALL set at the next rising edge; latency 1 cycle; other channels unchanged.
REQ-014 Consume: when enable=0, take[i]=1 and valid[i]=1, valid[i] SHALL clear at the next edge; out[i] retains its data.
REQ-015 take[i] with valid[i]=0 SHALL have no effect.
REQ-016 Simultaneous write and take on the same channel: write wins; data loaded, valid stays 1, overflow not set.
REQ-017 Write to a channel with valid=1 and take=0: data overwritten, valid stays 1, overflow[addr] SHALL set and hold until rst or flush.
REQ-018 Writes and takes on different channels in the same cycle SHALL both take effect.
REQ-019 Flush: when enable=1, at the next edge all out registers SHALL become 0, valid=0, overflow=0, occupancy=0; in_valid and take ignored that cycle.
REQ-020 occupancy SHALL equal the popcount of the valid value it is registered alongside, every cycle (no lag between valid and occupancy).
REQ-021 occupancy SHALL never exceed 8; a write to an occupied channel SHALL not increment it.
REQ-022 No output SHALL depend combinationally on any input; all outputs driven from registers.

Reset
REQ-023 rst=1 at a rising edge SHALL set out0..out7=0, valid=0, overflow=0, occupancy=0, overriding enable, in_valid and take.
REQ-024 Reset asserted mid-operation SHALL discard all held data; the first write after rst deasserts SHALL be accepted with normal 1-cycle latency.

Structure
REQ-025 Constants NUM_CH=8 and ADDR_W=3 SHALL live in the shared pipeline constants package, used by this block and by Mux_8 instantiations.
REQ-026 One sub-module, demux_8_slot (data register, valid, overflow for one channel, inputs: wr, take, flush), SHALL be instantiated 8 times; the top contains address decode and occupancy counter.

Verification
REQ-027 rst, then in_valid=1, addr=3, in=0xDEADBEEF -> next cycle out3=0xDEADBEEF, valid=0x08, occupancy=1, others 0.
REQ-028 Write addr=5 in=0x11, then addr=5 in=0x22 with take=0 -> out5=0x22, valid[5]=1, overflow=0x20, occupancy=1.
REQ-029 valid[2]=1; same cycle in_valid=1 addr=2 in=0x33, take=0x04 -> out2=0x33, valid[2]=1, overflow[2]=0; separately take=0x04 alone -> valid[2]=0, out2 unchanged, occupancy decrements.
REQ-030 Fill all 8 channels (addr 0..7, in=0x100+addr) -> valid=0xFF, occupancy=8; then enable=1 one cycle -> all outs 0, valid=0, overflow=0, occupancy=0.
REQ-031 enable=1 with in_valid=1 addr=1 in=0x55 -> no write; valid=0, out1=0.
REQ-032 Mid-stream rst with valid=0x0F, overflow=0x01 -> next cycle all outputs 0; following write addr=7 in=0x77 -> out7=0x77 one cycle later.

Source files
------------

// File: rtl/demux_8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_8_pkg
// Brief    : Shared pipeline constants for the 8-channel demux/mux family,
//            plus a small popcount helper for channel occupancy.
// Revision : 1.0 - initial release
// ============================================================================
package demux_8_pkg;

    localparam int NUM_CH = 8;
    localparam int ADDR_W = 3;
    localparam int OCC_W  = 4;

    // Number of set bits in a per-channel flag vector (0..NUM_CH).
    function automatic logic [OCC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt = cnt + {{(OCC_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_8_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_8_slot
// Brief    : One output channel: data register, occupied flag and sticky
//            overflow flag. Flush beats write, write beats take.
// Revision : 1.0 - initial release
// ============================================================================
module demux_8_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr,
    input  logic             i_take,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overflow,
    output logic             o_valid_nxt
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overflow;
    logic             w_valid_nxt;
    logic             w_overflow_nxt;

    // Next-state of the flags; the top uses the valid next-state so its
    // occupancy register updates on the same edge as the flags.
    always_comb begin
        w_valid_nxt    = r_valid;
        w_overflow_nxt = r_overflow;
        if (i_flush) begin
            w_valid_nxt    = 1'b0;
            w_overflow_nxt = 1'b0;
        end else if (i_wr) begin
            w_valid_nxt    = 1'b1;
            // Overwrite of data nobody consumed is an overflow; a take in the
            // same cycle means the old data was delivered.
            w_overflow_nxt = r_overflow | (r_valid & ~i_take);
        end else if (i_take) begin
            w_valid_nxt    = 1'b0;
        end
    end

    // Channel state registers; data is retained across a take.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid    <= w_valid_nxt;
            r_overflow <= w_overflow_nxt;
            if (i_flush) begin
                r_data <= '0;
            end else if (i_wr) begin
                r_data <= i_data;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_overflow  = r_overflow;
    assign o_valid_nxt = w_valid_nxt;

endmodule
`default_nettype wire

// File: rtl/demux_8.sv
`default_nettype none
// ============================================================================
// Module   : demux_8
// Brief    : 1-to-8 registered write demultiplexer with per-channel consume
//            handshake, sticky overflow flags and an occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module demux_8
    import demux_8_pkg::*;
#(
    parameter int width = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [width-1:0]    in,
    input  logic                in_valid,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   take,
    output logic [width-1:0]    out0,
    output logic [width-1:0]    out1,
    output logic [width-1:0]    out2,
    output logic [width-1:0]    out3,
    output logic [width-1:0]    out4,
    output logic [width-1:0]    out5,
    output logic [width-1:0]    out6,
    output logic [width-1:0]    out7,
    output logic [NUM_CH-1:0]   valid,
    output logic [NUM_CH-1:0]   overflow,
    output logic [OCC_W-1:0]    occupancy
);

    logic [width-1:0]  w_data [NUM_CH];
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_take;
    logic [NUM_CH-1:0] w_valid_nxt;
    logic [OCC_W-1:0]  r_occupancy;

    // enable is active-low: high means flush, and all requests are ignored.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
            assign w_wr[i]   = ~enable & in_valid & (addr == ADDR_W'(i));
            assign w_take[i] = ~enable & take[i];

            demux_8_slot #(
                .WIDTH (width)
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .i_flush     (enable),
                .i_wr        (w_wr[i]),
                .i_take      (w_take[i]),
                .i_data      (in),
                .o_data      (w_data[i]),
                .o_valid     (valid[i]),
                .o_overflow  (overflow[i]),
                .o_valid_nxt (w_valid_nxt[i])
            );
        end
    endgenerate

    // Occupancy is registered from next-state valid so it never lags valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= popcount(w_valid_nxt);
        end
    end

    assign occupancy = r_occupancy;
    assign out0 = w_data[0];
    assign out1 = w_data[1];
    assign out2 = w_data[2];
    assign out3 = w_data[3];
    assign out4 = w_data[4];
    assign out5 = w_data[5];
    assign out6 = w_data[6];
    assign out7 = w_data[7];

endmodule
`default_nettype wire

// File: tb/tb_demux_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_8
// Brief    : Directed self-checking bench for demux_8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_8;

    logic        clk;
    logic        rst;
    logic [2:0]  addr;
    logic [31:0] din;
    logic        in_valid;
    logic        enable;
    logic [7:0]  take;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]  valid;
    logic [7:0]  overflow;
    logic [3:0]  occupancy;
    logic [31:0] outs [8];

    int tests;
    int fails;

    demux_8 #(.width(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .in        (din),
        .in_valid  (in_valid),
        .enable    (enable),
        .take      (take),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .valid     (valid),
        .overflow  (overflow),
        .occupancy (occupancy)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        take     = 8'h00;
        enable   = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        addr     = a;
        din      = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (valid !== 8'h00) begin fails++; $display("FAIL reset_valid got=%h exp=00", valid); end
        tests++;
        if (overflow !== 8'h00) begin fails++; $display("FAIL reset_overflow got=%h exp=00", overflow); end
        tests++;
        if (occupancy !== 4'd0) begin fails++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (outs[i] !== 32'h0) begin fails++; $display("FAIL reset_out%0d got=%h exp=0", i, outs[i]); end
        end
    endtask

    task automatic test_write();
        do_reset();
        wr(3'd3, 32'hDEADBEEF);
        tests++;
        if (out3 !== 32'hDEADBEEF) begin fails++; $display("FAIL write_out3 got=%h exp=deadbeef", out3); end
        tests++;
        if (valid !== 8'h08) begin fails++; $display("FAIL write_valid got=%h exp=08", valid); end
        tests++;
        if (occupancy !== 4'd1) begin fails++; $display("FAIL write_occupancy got=%0d exp=1", occupancy); end
        tests++;
        if (overflow !== 8'h00) begin fails++; $display("FAIL write_overflow got=%h exp=00", overflow); end
        for (int i = 0; i < 8; i++) begin
            if (i != 3) begin
                tests++;
                if (outs[i] !== 32'h0) begin fails++; $display("FAIL write_other_out%0d got=%h exp=0", i, outs[i]); end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        wr(3'd5, 32'h11);
        wr(3'd5, 32'h22);
        tests++;
        if (out5 !== 32'h22) begin fails++; $display("FAIL ovf_out5 got=%h exp=22", out5); end
        tests++;
        if (valid !== 8'h20) begin fails++; $display("FAIL ovf_valid got=%h exp=20", valid); end
        tests++;
        if (overflow !== 8'h20) begin fails++; $display("FAIL ovf_flag got=%h exp=20", overflow); end
        tests++;
        if (occupancy !== 4'd1) begin fails++; $display("FAIL ovf_occupancy got=%0d exp=1", occupancy); end
        // Consuming the data must not clear the sticky flag.
        take = 8'h20;
        cyc();
        take = 8'h00;
        tests++;
        if (valid !== 8'h00) begin fails++; $display("FAIL ovf_take_valid got=%h exp=00", valid); end
        tests++;
        if (overflow !== 8'h20) begin fails++; $display("FAIL ovf_sticky got=%h exp=20", overflow); end
    endtask

    task automatic test_write_take_same();
        do_reset();
        wr(3'd2, 32'h10);
        take = 8'h04;
        wr(3'd2, 32'h33);
        take = 8'h00;
        tests++;
        if (out2 !== 32'h33) begin fails++; $display("FAIL wt_out2 got=%h exp=33", out2); end
        tests++;
        if (valid !== 8'h04) begin fails++; $display("FAIL wt_valid got=%h exp=04", valid); end
        tests++;
        if (overflow !== 8'h00) begin fails++; $display("FAIL wt_overflow got=%h exp=00", overflow); end
        tests++;
        if (occupancy !== 4'd1) begin fails++; $display("FAIL wt_occupancy got=%0d exp=1", occupancy); end
        take = 8'h04;
        cyc();
        tests++;
        if (valid !== 8'h00) begin fails++; $display("FAIL take_valid got=%h exp=00", valid); end
        tests++;
        if (out2 !== 32'h33) begin fails++; $display("FAIL take_out2_kept got=%h exp=33", out2); end
        tests++;
        if (occupancy !== 4'd0) begin fails++; $display("FAIL take_occupancy got=%0d exp=0", occupancy); end
        // Take on an empty channel has no effect.
        cyc();
        take = 8'h00;
        tests++;
        if (valid !== 8'h00 || overflow !== 8'h00 || out2 !== 32'h33) begin
            fails++;
            $display("FAIL take_empty got valid=%h ovf=%h out2=%h exp 00/00/33", valid, overflow, out2);
        end
    endtask

    task automatic test_diff_channels();
        do_reset();
        wr(3'd1, 32'hA);
        take = 8'h02;
        wr(3'd6, 32'hB);
        take = 8'h00;
        tests++;
        if (valid !== 8'h40) begin fails++; $display("FAIL diff_valid got=%h exp=40", valid); end
        tests++;
        if (out6 !== 32'hB || out1 !== 32'hA) begin
            fails++;
            $display("FAIL diff_data got out6=%h out1=%h exp b/a", out6, out1);
        end
        tests++;
        if (occupancy !== 4'd1) begin fails++; $display("FAIL diff_occupancy got=%0d exp=1", occupancy); end
    endtask

    task automatic test_fill_flush();
        do_reset();
        for (int a = 0; a < 8; a++) begin
            wr(3'(a), 32'h100 + 32'(a));
        end
        tests++;
        if (valid !== 8'hFF) begin fails++; $display("FAIL fill_valid got=%h exp=ff", valid); end
        tests++;
        if (occupancy !== 4'd8) begin fails++; $display("FAIL fill_occupancy got=%0d exp=8", occupancy); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (outs[i] !== 32'h100 + 32'(i)) begin
                fails++;
                $display("FAIL fill_out%0d got=%h exp=%h", i, outs[i], 32'h100 + 32'(i));
            end
        end
        wr(3'd0, 32'h200);
        tests++;
        if (occupancy !== 4'd8 || overflow !== 8'h01) begin
            fails++;
            $display("FAIL full_overwrite got occ=%0d ovf=%h exp 8/01", occupancy, overflow);
        end
        enable   = 1'b1;
        in_valid = 1'b1;
        addr     = 3'd2;
        din      = 32'hFFFF;
        take     = 8'hFF;
        cyc();
        idle();
        tests++;
        if (valid !== 8'h00 || overflow !== 8'h00 || occupancy !== 4'd0) begin
            fails++;
            $display("FAIL flush_flags got valid=%h ovf=%h occ=%0d exp 00/00/0", valid, overflow, occupancy);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (outs[i] !== 32'h0) begin fails++; $display("FAIL flush_out%0d got=%h exp=0", i, outs[i]); end
        end
    endtask

    task automatic test_flush_blocks_write();
        do_reset();
        enable = 1'b1;
        wr(3'd1, 32'h55);
        enable = 1'b0;
        tests++;
        if (valid !== 8'h00 || out1 !== 32'h0) begin
            fails++;
            $display("FAIL flush_blocks got valid=%h out1=%h exp 00/0", valid, out1);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        for (int a = 0; a < 4; a++) begin
            wr(3'(a), 32'h40 + 32'(a));
        end
        wr(3'd0, 32'h99);
        tests++;
        if (valid !== 8'h0F || overflow !== 8'h01) begin
            fails++;
            $display("FAIL pre_rst got valid=%h ovf=%h exp 0f/01", valid, overflow);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        addr     = 3'd4;
        din      = 32'h44;
        cyc();
        idle();
        tests++;
        if (valid !== 8'h00 || overflow !== 8'h00 || occupancy !== 4'd0 || out0 !== 32'h0 || out4 !== 32'h0) begin
            fails++;
            $display("FAIL mid_rst got valid=%h ovf=%h occ=%0d out0=%h out4=%h exp all 0",
                     valid, overflow, occupancy, out0, out4);
        end
        wr(3'd7, 32'h77);
        tests++;
        if (out7 !== 32'h77 || valid !== 8'h80 || occupancy !== 4'd1) begin
            fails++;
            $display("FAIL post_rst_write got out7=%h valid=%h occ=%0d exp 77/80/1", out7, valid, occupancy);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        addr     = 3'd0;
        din      = 32'h0;
        idle();
        test_reset();
        test_write();
        test_overflow();
        test_write_take_same();
        test_diff_channels();
        test_fill_flush();
        test_flush_blocks_write();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
